// File: rtl/frame_draw_scheduler.sv
// Per-frame sequencer for the character layer: erase old sprites, step game logic,
// then release the display controller for one pass, arbitrating the VGA write port.
module frame_draw_scheduler #(
  parameter int unsigned FRAME_CYCLES = 833333,
  parameter int unsigned NUM_CHARS    = 5,
  parameter int unsigned SPRITE_DIM   = 5,
  parameter int unsigned X_OFFSET     = 26,
  parameter int unsigned Y_OFFSET     = 1,
  parameter int unsigned DRAW_CYCLES  = 125
) (
  input  logic       clock_50,
  input  logic       resetn,
  input  logic       en,
  input  logic [7:0] char_x,
  input  logic [7:0] char_y,
  output logic [2:0] char_sel,
  input  logic [2:0] drw_char_type,
  input  logic       drw_plot,
  input  logic [7:0] drw_x,
  input  logic [7:0] drw_y,
  input  logic [2:0] drw_color,
  output logic       drw_reset,
  output logic       logic_step,
  input  logic       logic_done,
  output logic       vga_plot,
  output logic [7:0] vga_x,
  output logic [7:0] vga_y,
  output logic [2:0] vga_color,
  output logic       busy,
  output logic       frame_overrun
);

  localparam int unsigned CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int unsigned CHR_W = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
  localparam int unsigned PIX_W = (SPRITE_DIM > 1) ? $clog2(SPRITE_DIM) : 1;
  localparam int unsigned DRW_W = (DRAW_CYCLES > 1) ? $clog2(DRAW_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ERASE      = 3'd1,
    STEP       = 3'd2,
    WAIT_LOGIC = 3'd3,
    DRAW       = 3'd4
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] frame_cnt_q;
  logic [CHR_W-1:0] chr_q;
  logic [PIX_W-1:0] sx_q;
  logic [PIX_W-1:0] sy_q;
  logic [DRW_W-1:0] drw_cnt_q;
  logic             pending_q;
  logic             overrun_q;
  logic             tick_c;

  assign tick_c        = (frame_cnt_q == CNT_W'(FRAME_CYCLES - 1));
  assign frame_overrun = overrun_q;

  // Free-running frame timebase, independent of en and FSM state.
  always_ff @(posedge clock_50 or negedge resetn) begin
    if (!resetn) begin
      frame_cnt_q <= '0;
    end else if (tick_c) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock_50 or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      chr_q     <= '0;
      sx_q      <= '0;
      sy_q      <= '0;
      drw_cnt_q <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          pending_q <= 1'b0;
          if (en && (tick_c || pending_q)) begin
            state_q <= ERASE;
            chr_q   <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
          end
        end
        ERASE: begin
          // Raster order: sx fastest, then sy, then character index.
          if (sx_q == PIX_W'(SPRITE_DIM - 1)) begin
            sx_q <= '0;
            if (sy_q == PIX_W'(SPRITE_DIM - 1)) begin
              sy_q <= '0;
              if (chr_q == CHR_W'(NUM_CHARS - 1)) begin
                chr_q   <= '0;
                state_q <= STEP;
              end else begin
                chr_q <= chr_q + CHR_W'(1);
              end
            end else begin
              sy_q <= sy_q + PIX_W'(1);
            end
          end else begin
            sx_q <= sx_q + PIX_W'(1);
          end
        end
        STEP: state_q <= WAIT_LOGIC;
        WAIT_LOGIC: begin
          if (logic_done) begin
            state_q   <= DRAW;
            drw_cnt_q <= DRW_W'(DRAW_CYCLES - 1);
          end
        end
        DRAW: begin
          if (drw_cnt_q == '0) begin
            state_q <= IDLE;
          end else begin
            drw_cnt_q <= drw_cnt_q - DRW_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase

      // One-deep tick queue while a frame is in flight; a second tick is an overrun.
      if ((state_q != IDLE) && tick_c) begin
        if (pending_q) begin
          overrun_q <= 1'b1;
        end else begin
          pending_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    char_sel   = 3'd0;
    drw_reset  = 1'b1;
    logic_step = 1'b0;
    vga_plot   = 1'b0;
    vga_x      = 8'd0;
    vga_y      = 8'd0;
    vga_color  = 3'd0;
    busy       = (state_q != IDLE);
    case (state_q)
      ERASE: begin
        char_sel  = 3'(chr_q);
        vga_plot  = 1'b1;
        vga_x     = char_x + 8'(sx_q) + 8'(X_OFFSET);
        vga_y     = char_y + 8'(sy_q) + 8'(Y_OFFSET);
        vga_color = 3'b000;
      end
      STEP: logic_step = 1'b1;
      DRAW: begin
        drw_reset = 1'b0;
        char_sel  = drw_char_type;
        vga_plot  = drw_plot;
        vga_x     = drw_x;
        vga_y     = drw_y;
        vga_color = drw_color;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// Directed bench: instance A (400-cycle frames) covers erase/step/draw and en drop,
// instance B (100-cycle frames) covers pending/overrun and reset during DRAW.
module tb_frame_draw_scheduler;

  logic       clk = 1'b0;
  logic       resetn;
  logic       en_a, en_b, ld_a, ld_b;
  logic [2:0] drw_char_type;
  logic       drw_plot;
  logic [7:0] drw_x, drw_y;
  logic [2:0] drw_color;

  logic [7:0] a_char_x, a_char_y, b_char_x, b_char_y;
  logic [2:0] a_char_sel, b_char_sel;
  logic       a_drw_reset, a_logic_step, a_vga_plot, a_busy, a_overrun;
  logic       b_drw_reset, b_logic_step, b_vga_plot, b_busy, b_overrun;
  logic [7:0] a_vga_x, a_vga_y, b_vga_x, b_vga_y;
  logic [2:0] a_vga_color, b_vga_color;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] cx(input logic [2:0] s);
    return 8'(10 + 20 * int'(s));
  endfunction
  function automatic logic [7:0] cy(input logic [2:0] s);
    return 8'(20 + 10 * int'(s));
  endfunction

  assign a_char_x = cx(a_char_sel);
  assign a_char_y = cy(a_char_sel);
  assign b_char_x = cx(b_char_sel);
  assign b_char_y = cy(b_char_sel);

  frame_draw_scheduler #(.FRAME_CYCLES(400)) dut_a (
    .clock_50(clk), .resetn(resetn), .en(en_a),
    .char_x(a_char_x), .char_y(a_char_y), .char_sel(a_char_sel),
    .drw_char_type(drw_char_type), .drw_plot(drw_plot), .drw_x(drw_x),
    .drw_y(drw_y), .drw_color(drw_color), .drw_reset(a_drw_reset),
    .logic_step(a_logic_step), .logic_done(ld_a),
    .vga_plot(a_vga_plot), .vga_x(a_vga_x), .vga_y(a_vga_y),
    .vga_color(a_vga_color), .busy(a_busy), .frame_overrun(a_overrun)
  );

  frame_draw_scheduler #(.FRAME_CYCLES(100)) dut_b (
    .clock_50(clk), .resetn(resetn), .en(en_b),
    .char_x(b_char_x), .char_y(b_char_y), .char_sel(b_char_sel),
    .drw_char_type(drw_char_type), .drw_plot(drw_plot), .drw_x(drw_x),
    .drw_y(drw_y), .drw_color(drw_color), .drw_reset(b_drw_reset),
    .logic_step(b_logic_step), .logic_done(ld_b),
    .vga_plot(b_vga_plot), .vga_x(b_vga_x), .vga_y(b_vga_y),
    .vga_color(b_vga_color), .busy(b_busy), .frame_overrun(b_overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int t);
    while (cyc < t) step();
  endtask

  initial begin
    int  lo_cnt;
    bit  idle_bad;
    resetn = 1'b0; en_a = 1'b0; en_b = 1'b0; ld_a = 1'b0; ld_b = 1'b0;
    drw_char_type = 3'd0; drw_plot = 1'b0; drw_x = 8'd0; drw_y = 8'd0; drw_color = 3'd0;

    // Reset held for 3 cycles
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", a_busy, 0);
    chk("rst_drw_reset", a_drw_reset, 1);
    chk("rst_plot", a_vga_plot, 0);
    chk("rst_x", a_vga_x, 0);
    chk("rst_y", a_vga_y, 0);
    chk("rst_color", a_vga_color, 0);
    chk("rst_sel", a_char_sel, 0);
    chk("rst_step", a_logic_step, 0);
    chk("rst_ovr", a_overrun, 0);
    en_a = 1'b1;
    resetn = 1'b1;
    cyc = 0;
    #1;
    chk("post_rst_busy", a_busy, 0);
    chk("post_rst_drw_reset", a_drw_reset, 1);

    // Tick at counter 399, erase starts on the next cycle
    goto(399);
    chk("tick_cycle_idle", a_busy, 0);
    goto(400);
    chk("erase0_busy", a_busy, 1);
    chk("erase0_plot", a_vga_plot, 1);
    chk("erase0_x", a_vga_x, 36);
    chk("erase0_y", a_vga_y, 21);
    chk("erase0_color", a_vga_color, 0);
    chk("erase0_sel", a_char_sel, 0);
    for (int i = 0; i < 125; i++) begin
      int c, sx, sy;
      if (i > 0) step();
      c = i / 25; sy = (i / 5) % 5; sx = i % 5;
      chk("erase_sel", a_char_sel, 32'(c));
      chk("erase_x", a_vga_x, 32'(8'(10 + 20 * c + sx + 26)));
      chk("erase_y", a_vga_y, 32'(8'(20 + 10 * c + sy + 1)));
      chk("erase_plot", a_vga_plot, 1);
    end
    chk("erase_last_x", a_vga_x, 120);
    chk("erase_last_y", a_vga_y, 65);

    // STEP pulse, then logic_done 7 cycles later
    goto(525);
    chk("step_pulse", a_logic_step, 1);
    chk("step_plot", a_vga_plot, 0);
    chk("step_busy", a_busy, 1);
    goto(526);
    chk("step_one_cycle", a_logic_step, 0);
    chk("wait_drw_reset", a_drw_reset, 1);
    goto(532);
    ld_a = 1'b1;
    #1;
    chk("wait_hold_drw_reset", a_drw_reset, 1);
    chk("wait_plot", a_vga_plot, 0);

    // DRAW: pass-through for exactly 125 cycles
    lo_cnt = 0;
    for (int i = 0; i < 125; i++) begin
      step();
      drw_x = 8'(i * 7 + 3); drw_y = 8'(i * 3); drw_color = 3'(i);
      drw_plot = i[0]; drw_char_type = 3'(i / 25);
      #1;
      if (a_drw_reset === 1'b0) lo_cnt++;
      chk("draw_x", a_vga_x, 32'(drw_x));
      chk("draw_y", a_vga_y, 32'(drw_y));
      chk("draw_color", a_vga_color, 32'(drw_color));
      chk("draw_plot", a_vga_plot, 32'(drw_plot));
      chk("draw_sel", a_char_sel, 32'(drw_char_type));
    end
    chk("draw_low_cycles", lo_cnt, 125);
    drw_plot = 1'b1;
    step();
    chk("draw_end_drw_reset", a_drw_reset, 1);
    chk("draw_end_busy", a_busy, 0);
    chk("draw_end_plot", a_vga_plot, 0);
    chk("a_no_overrun", a_overrun, 0);

    // en dropped mid-erase: frame completes, no further frames
    goto(800);
    chk("f2_start", a_busy, 1);
    goto(810);
    en_a = 1'b0;
    goto(1051);
    chk("f2_last_busy", a_busy, 1);
    goto(1052);
    chk("f2_idle", a_busy, 0);
    idle_bad = 1'b0;
    while (cyc < 2010) begin
      step();
      if (a_busy !== 1'b0) idle_bad = 1'b1;
    end
    chk("en_off_stays_idle", 32'(idle_bad), 0);

    // Instance B: 100-cycle frames with logic_done tied high
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("b_rst_ovr", b_overrun, 0);
    en_b = 1'b1; ld_b = 1'b1; drw_plot = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    cyc = 0;
    #1;
    goto(99);
    chk("b_tick_idle", b_busy, 0);
    goto(100);
    chk("b_f1_start", b_busy, 1);
    goto(200);
    chk("b_pending_no_ovr", b_overrun, 0);
    goto(299);
    chk("b_before_2nd_tick", b_overrun, 0);
    goto(300);
    chk("b_overrun_set", b_overrun, 1);
    goto(351);
    chk("b_f1_last", b_busy, 1);
    goto(352);
    chk("b_idle_one", b_busy, 0);
    goto(353);
    chk("b_f2_start", b_busy, 1);
    chk("b_f2_plot", b_vga_plot, 1);
    chk("b_f2_x", b_vga_x, 36);
    chk("b_ovr_sticky", b_overrun, 1);
    goto(479);
    chk("b_wait_drw_reset", b_drw_reset, 1);
    goto(480);
    chk("b_draw_start", b_drw_reset, 0);

    // Asynchronous reset during DRAW cycle 60
    goto(540);
    drw_plot = 1'b1;
    #1;
    chk("b_draw60_plot", b_vga_plot, 1);
    chk("b_draw60_drw_reset", b_drw_reset, 0);
    resetn = 1'b0;
    #1;
    chk("b_abort_plot", b_vga_plot, 0);
    chk("b_abort_drw_reset", b_drw_reset, 1);
    chk("b_abort_busy", b_busy, 0);
    chk("b_abort_ovr", b_overrun, 0);
    @(negedge clk);
    resetn = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_draw_scheduler.md
Name: frame_draw_scheduler

Overview:
- Top-level per-frame sequencer for the character layer on the VGA adapter.
- On each frame tick it runs three phases in order: erases all characters at their old positions, then has the game logic advance one step, then runs the character display controller for one full pass.
- It arbitrates the single VGA write port and the CharacterRegisters select lines between its own erase engine and the character display controller.

Parameters:
FRAME_CYCLES, 833333, clock_50 cycles per frame tick (60 Hz at 50 MHz).
NUM_CHARS, 5, characters per frame (Pacman plus 4 ghosts), indices 0..NUM_CHARS-1.
SPRITE_DIM, 5, sprite edge length in pixels.
X_OFFSET, 26, screen x offset added to char_x.
Y_OFFSET, 1, screen y offset added to char_y.
DRAW_CYCLES, 125, cycles the display controller is released per frame (NUM_CHARS*SPRITE_DIM*SPRITE_DIM).

Ports:
clock_50  in  1  system clock; all state changes on its rising edge.
resetn  in  1  asynchronous, active-low reset.
en  in  1  frame-start enable.
char_x  in  8  x position from CharacterRegisters for the current char_sel.
char_y  in  8  y position from CharacterRegisters for the current char_sel.
char_sel  out  3  character index driven to CharacterRegisters.
drw_char_type  in  3  character_type output of the display controller.
drw_plot  in  1  display controller vga_plot.
drw_x  in  8  display controller vga_x.
drw_y  in  8  display controller vga_y.
drw_color  in  3  display controller vga_color.
drw_reset  out  1  active-high reset to the display controller.
logic_step  out  1  one-cycle pulse requesting one game-logic step.
logic_done  in  1  game logic finished the step; sampled only in WAIT_LOGIC.
vga_plot  out  1  write enable to the VGA adapter.
vga_x  out  8  VGA x coordinate.
vga_y  out  8  VGA y coordinate.
vga_color  out  3  VGA color.
busy  out  1  high in every state except IDLE.
frame_overrun  out  1  sticky flag; set when a tick arrives while a tick is already pending.

Behaviour:
- Reset (resetn=0, asynchronous) forces:
  - state IDLE; frame counter, erase counters, pending flag and frame_overrun all 0.
  - drw_reset=1, logic_step=0, vga_plot=0, vga_x=0, vga_y=0, vga_color=0, char_sel=0, busy=0.
- Frame counter:
  - Counts 0..FRAME_CYCLES-1 and wraps; runs regardless of en or state.
  - A tick is asserted in the cycle the counter equals FRAME_CYCLES-1.
- Tick handling:
  - In IDLE with en=1, a tick or a set pending flag moves the FSM to ERASE on the next edge and clears pending.
  - In IDLE with en=0, ticks are ignored and pending is cleared.
  - In any other state, a tick sets pending; if pending is already 1, frame_overrun is set instead (one-deep queue).
- ERASE:
  - Counters chr (0..NUM_CHARS-1), sx and sy (0..SPRITE_DIM-1) scan sx fastest, then sy, then chr.
  - Exactly NUM_CHARS*SPRITE_DIM^2 cycles.
  - Outputs: char_sel=chr, vga_plot=1, vga_color=3'b000, vga_x=char_x+sx+X_OFFSET, vga_y=char_y+sy+Y_OFFSET.
  - Coordinate arithmetic is 8-bit and wraps modulo 256.
  - After the last pixel (chr=NUM_CHARS-1, sx=sy=SPRITE_DIM-1), go to STEP.
- STEP:
  - One cycle, logic_step=1, vga_plot=0; then go to WAIT_LOGIC.
- WAIT_LOGIC:
  - vga_plot=0; hold until logic_done=1, then go to DRAW on the next edge.
  - No timeout.
  - A logic_done seen in any other state is ignored.
- DRAW:
  - drw_reset=0 for exactly DRAW_CYCLES cycles, tracked by a down-counter.
  - vga_plot/vga_x/vga_y/vga_color pass through drw_* combinationally; char_sel=drw_char_type.
  - After the last cycle, drw_reset=1 and the FSM returns to IDLE.
- Outside DRAW:
  - drw_reset=1, so every DRAW pass starts at character 0, pixel (0,0).
  - char_sel=0 in IDLE, STEP and WAIT_LOGIC.
- Output timing:
  - All outputs are combinational functions of registered state and the listed inputs.
  - No glitch requirement beyond single-cycle validity at the clock edge.
- en deasserted mid-frame: the current frame runs to IDLE; no new frame starts.
- resetn asserted mid-frame: immediate abort to the reset values above; the partial erase or draw is not completed.
- Minimum frame length is 1+125+1+1+125 cycles plus logic latency. A smaller FRAME_CYCLES is legal and exercises the overrun path.

Test Plan:
1. Hold resetn=0 for 3 cycles, then release -> all outputs at reset values; busy=0; drw_reset=1.
2. FRAME_CYCLES=400, en=1, char_sel=0 returns char_x=10/char_y=20 -> tick at cycle 399; ERASE first pixel vga_x=36, vga_y=21, color 000, plot=1; 125 erase cycles, last with char_sel=4, offset (4,4).
3. logic_done returned 7 cycles after the logic_step pulse -> logic_step high exactly 1 cycle; DRAW begins the cycle after logic_done; drw_reset low exactly 125 cycles; vga_* equals drw_* during DRAW.
4. FRAME_CYCLES=100, logic_done tied 1 -> pending set on the first in-frame tick; frame_overrun=1 after the second; the next frame starts 1 cycle after IDLE is entered.
5. en dropped to 0 mid-ERASE -> frame completes through DRAW; remains IDLE through the next 3 ticks, busy=0.
6. resetn pulsed low during DRAW cycle 60 -> same cycle: vga_plot=0, drw_reset=1, state IDLE, frame_overrun=0.
